ifft_8: RTL and testbench
=========================

IFFT_8 -- requirements
Module: ifft_8

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 12-bit signed two's complement, the transform size at 8, and the twiddle format at Q1.10 (1024 = 1.0).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  input sample present on X_r/X_i.
REQ-005 in_ready  output  1  block accepts an input sample this cycle.
REQ-006 X_r, X_i  input  12 signed  frequency-domain sample, natural order X[0]..X[7].
REQ-007 out_valid  output  1  output sample present on x_r/x_i.
REQ-008 out_ready  input  1  downstream accepts the output sample this cycle.
REQ-009 x_r, x_i  output  12 signed  time-domain sample, natural order x[0]..x[7].
REQ-010 out_last  output  1  high together with out_valid on x[7] only.

Function
REQ-011 The block SHALL compute x[n] = (1/8)·Σ X[k]·e^(+j2πnk/8) using an in-place radix-2 DIT schedule over an 8-entry complex register memory.
REQ-012 FSM states SHALL be:
- LOAD: in_ready=1.
- COMPUTE: in_ready=0, out_valid=0.
- UNLOAD: out_valid=1.
REQ-013 LOAD: each in_valid&in_ready beat SHALL write the sample to memory address bitrev3(load_cnt) and increment load_cnt; the 8th beat SHALL transition to COMPUTE. Cycles with in_valid=0 SHALL leave state unchanged.
REQ-014 COMPUTE SHALL take exactly 12 cycles, one butterfly per cycle, stage s=0..2 and butterfly j=0..3 in order.
REQ-015 Butterfly addressing:
- span = 2^s, pos = j mod span, p = (j div span)·2·span + pos, q = p + span.
- Twiddle index k = pos·2^(2−s).
REQ-016 The conjugate twiddle table SHALL be k0=(1024,0), k1=(724,724), k2=(0,1024), k3=(−724,724).
REQ-017 Butterfly arithmetic:
- t = mem[q]·w, full-precision complex product, arithmetic shift right 10.
- mem[p] ← sat12((mem[p]+t) >>> 1).
- mem[q] ← sat12((mem[p]−t) >>> 1).
- Both results use the pre-update mem[p].
REQ-018 sat12 SHALL clamp to [−2048, 2047]; shifts SHALL be arithmetic (floor) with no rounding.
REQ-019 After the 12th COMPUTE cycle the FSM SHALL enter UNLOAD with out_idx=0.
REQ-020 UNLOAD: x_r/x_i SHALL equal mem[out_idx]; out_idx SHALL advance only on out_valid&out_ready; the beat with out_idx=7 SHALL assert out_last and return the FSM to LOAD with load_cnt=0.
REQ-021 While out_ready=0, x_r, x_i, out_last and out_valid SHALL hold stable.
REQ-022 Latency: if the 8th input is accepted at edge t, out_valid SHALL rise after edge t+12 (12 COMPUTE cycles) and x[0] SHALL be valid from then on.
REQ-023 in_ready and out_valid SHALL never be high in the same cycle; the block SHALL not accept input during COMPUTE or UNLOAD.

Reset
REQ-024 While rst=1: state=LOAD, load_cnt=0, out_idx=0, all memory entries=0, out_valid=0, out_last=0, x_r=x_i=0, in_ready=0.
REQ-025 After rst deasserts, in_ready SHALL be 1 on the next cycle.
REQ-026 A reset asserted in any state SHALL abort the frame in progress; no partial frame data SHALL appear after release.

Verification
REQ-027 Impulse: X[0]=(1024,0), X[1..7]=0 -> eight outputs each (128,0); out_last on the 8th beat only.
REQ-028 DC: all X[k]=(1024,0) -> x[0]=(1024,0), x[1..7]=(0,0).
REQ-029 Single bin: X[1]=(1024,0), rest 0 -> x[n]≈128·e^(+j2πn/8), e.g. x[1]≈(90,90), x[2]=(0,128), x[4]=(−128,0), within ±2 LSB.
REQ-030 Handshake: random in_valid gaps plus out_ready held low 5 cycles at out_idx=3 -> identical results, outputs stable while stalled, in_ready=0 throughout COMPUTE/UNLOAD, out_valid exactly 12 cycles after the 8th accept.
REQ-031 Saturation: all X[k]=(2047,2047) and all X[k]=(−2048,−2048) -> every output within [−2048, 2047], and results match a bit-accurate model of REQ-017/REQ-018.
REQ-032 Reset mid-operation: assert rst at COMPUTE cycle 6 and again at UNLOAD out_idx=4 -> out_valid=0 immediately, in_ready=1 after release, and the next impulse frame yields eight (128,0) outputs.

Source files
------------

// File: rtl/ifft_8_if.sv
// Streaming bus for the 8-point IFFT: input sample channel and output sample channel.
// Both channels use valid/ready: a beat transfers on a rising clock edge where
// valid and ready are both high; the sender holds data stable while valid is high
// and ready is low.
interface ifft_8_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [11:0] X_r;
   logic signed [11:0] X_i;
   logic               out_valid;
   logic               out_ready;
   logic signed [11:0] x_r;
   logic signed [11:0] x_i;
   logic               out_last;

   // Block side of the bus
   modport slave (
      input  in_valid, X_r, X_i, out_ready,
      output in_ready, out_valid, x_r, x_i, out_last
   );

   // Producer/consumer side of the bus
   modport master (
      output in_valid, X_r, X_i, out_ready,
      input  in_ready, out_valid, x_r, x_i, out_last
   );
endinterface

// File: rtl/ifft_8.sv
// 8-point inverse FFT, 12-bit complex samples, in-place radix-2 DIT over an
// 8-entry register memory. Frames are loaded in bit-reversed address order,
// transformed with one butterfly per cycle (12 cycles), then unloaded in
// natural order. Each stage halves its results, giving the overall 1/8 scale.
module ifft_8 (
   input  logic       clk,
   input  logic       rst,
   ifft_8_if.slave    bus,
   output logic [1:0] dbg_state
);

   localparam logic [1:0] ST_LOAD    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_UNLOAD  = 2'd2;

   logic [1:0]         state;
   logic [2:0]         load_cnt;
   logic [2:0]         out_idx;
   logic [3:0]         bf_cnt;
   logic signed [11:0] mem_r [8];
   logic signed [11:0] mem_i [8];

   // Butterfly datapath signals
   logic [1:0]         stage;
   logic [1:0]         bf_j;
   logic [2:0]         addr_p;
   logic [2:0]         addr_q;
   logic [1:0]         tw_k;
   logic signed [11:0] w_r, w_i;
   logic signed [11:0] p_r, p_i, q_r, q_i;
   logic signed [23:0] m_rr, m_ii, m_ri, m_ir;
   logic signed [24:0] prod_r, prod_i;
   logic signed [14:0] t_r, t_i;
   logic signed [15:0] sum_r, sum_i, dif_r, dif_i;
   logic signed [11:0] new_p_r, new_p_i, new_q_r, new_q_i;

   function automatic logic [2:0] bitrev3(input logic [2:0] a);
      return {a[0], a[1], a[2]};
   endfunction

   // Clamp a halved butterfly result into the 12-bit signed range
   function automatic logic signed [11:0] sat12(input logic signed [14:0] v);
      if (v > 15'sd2047)
         return 12'sd2047;
      else if (v < -15'sd2048)
         return -12'sd2048;
      else
         return v[11:0];
   endfunction

   assign stage = bf_cnt[3:2];
   assign bf_j  = bf_cnt[1:0];

   // Butterfly pair addresses and twiddle index for the current stage/butterfly
   always_comb begin
      addr_p = 3'd0;
      addr_q = 3'd0;
      tw_k   = 2'd0;
      case (stage)
         2'd0: begin
            addr_p = {bf_j, 1'b0};
            addr_q = {bf_j, 1'b1};
            tw_k   = 2'd0;
         end
         2'd1: begin
            addr_p = {bf_j[1], 1'b0, bf_j[0]};
            addr_q = {bf_j[1], 1'b1, bf_j[0]};
            tw_k   = {bf_j[0], 1'b0};
         end
         default: begin
            addr_p = {1'b0, bf_j};
            addr_q = {1'b1, bf_j};
            tw_k   = bf_j;
         end
      endcase
   end

   // Conjugate twiddle table in Q1.10 (positive-exponent rotation for the inverse)
   always_comb begin
      w_r = 12'sd1024;
      w_i = 12'sd0;
      case (tw_k)
         2'd0: begin w_r = 12'sd1024; w_i = 12'sd0;    end
         2'd1: begin w_r = 12'sd724;  w_i = 12'sd724;  end
         2'd2: begin w_r = 12'sd0;    w_i = 12'sd1024; end
         default: begin w_r = -12'sd724; w_i = 12'sd724; end
      endcase
   end

   // Complex multiply at full precision, single floor shift, then halved add/sub
   always_comb begin
      p_r     = mem_r[addr_p];
      p_i     = mem_i[addr_p];
      q_r     = mem_r[addr_q];
      q_i     = mem_i[addr_q];
      m_rr    = 24'(q_r) * 24'(w_r);
      m_ii    = 24'(q_i) * 24'(w_i);
      m_ri    = 24'(q_r) * 24'(w_i);
      m_ir    = 24'(q_i) * 24'(w_r);
      prod_r  = 25'(m_rr) - 25'(m_ii);
      prod_i  = 25'(m_ri) + 25'(m_ir);
      t_r     = prod_r[24:10];
      t_i     = prod_i[24:10];
      sum_r   = 16'(p_r) + 16'(t_r);
      sum_i   = 16'(p_i) + 16'(t_i);
      dif_r   = 16'(p_r) - 16'(t_r);
      dif_i   = 16'(p_i) - 16'(t_i);
      new_p_r = sat12(sum_r[15:1]);
      new_p_i = sat12(sum_i[15:1]);
      new_q_r = sat12(dif_r[15:1]);
      new_q_i = sat12(dif_i[15:1]);
   end

   // FSM, counters and sample memory
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_LOAD;
         load_cnt <= 3'd0;
         out_idx  <= 3'd0;
         bf_cnt   <= 4'd0;
         for (int a = 0; a < 8; a++) begin
            mem_r[a] <= 12'sd0;
            mem_i[a] <= 12'sd0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (bus.in_valid) begin
                  mem_r[bitrev3(load_cnt)] <= bus.X_r;
                  mem_i[bitrev3(load_cnt)] <= bus.X_i;
                  load_cnt <= load_cnt + 3'd1;
                  if (load_cnt == 3'd7) begin
                     state  <= ST_COMPUTE;
                     bf_cnt <= 4'd0;
                  end
               end
            end
            ST_COMPUTE: begin
               mem_r[addr_p] <= new_p_r;
               mem_i[addr_p] <= new_p_i;
               mem_r[addr_q] <= new_q_r;
               mem_i[addr_q] <= new_q_i;
               bf_cnt <= bf_cnt + 4'd1;
               if (bf_cnt == 4'd11) begin
                  state   <= ST_UNLOAD;
                  out_idx <= 3'd0;
               end
            end
            ST_UNLOAD: begin
               if (bus.out_ready) begin
                  if (out_idx == 3'd7) begin
                     state    <= ST_LOAD;
                     load_cnt <= 3'd0;
                     out_idx  <= 3'd0;
                  end else begin
                     out_idx <= out_idx + 3'd1;
                  end
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

   // Handshake and output data; memory is cleared by reset so outputs read zero then
   always_comb begin
      bus.in_ready  = (state == ST_LOAD) && !rst;
      bus.out_valid = (state == ST_UNLOAD);
      bus.out_last  = (state == ST_UNLOAD) && (out_idx == 3'd7);
      bus.x_r       = mem_r[out_idx];
      bus.x_i       = mem_i[out_idx];
      dbg_state     = state;
   end

endmodule

// File: tb/tb_ifft_8.sv
// Bench for ifft_8: directed frames (impulse, DC, single bin, saturation),
// randomized frames with input gaps and output stalls, and mid-frame resets.
// Expected samples come from an array-based IFFT model built from the butterfly rules.
module tb_ifft_8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ifft_8_if bus ();
   logic [1:0] dbg_state;

   ifft_8 dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;
   int in_r [8];
   int in_i [8];
   int got_r [8];
   int got_i [8];
   int acc_cyc;
   logic [23:0] exp_q [$];

   localparam int TW_R [4] = '{1024, 724, 0, -724};
   localparam int TW_I [4] = '{0, 724, 1024, 724};

   function automatic int brev(input int k);
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
   endfunction

   function automatic int clamp12(input int v);
      if (v > 2047) return 2047;
      if (v < -2048) return -2048;
      return v;
   endfunction

   // Reference IFFT: bit-reversed load, three stages of scaled butterflies
   task automatic model_push();
      int mr [8];
      int mi [8];
      int span, pos, p, q, k, tr, ti, pr, pi;
      logic [11:0] er, ei;
      for (int n = 0; n < 8; n++) begin
         mr[brev(n)] = in_r[n];
         mi[brev(n)] = in_i[n];
      end
      for (int s = 0; s < 3; s++) begin
         span = 1 << s;
         for (int j = 0; j < 4; j++) begin
            pos = j % span;
            p   = (j / span) * 2 * span + pos;
            q   = p + span;
            k   = pos * (1 << (2 - s));
            tr  = (mr[q] * TW_R[k] - mi[q] * TW_I[k]) >>> 10;
            ti  = (mr[q] * TW_I[k] + mi[q] * TW_R[k]) >>> 10;
            pr  = mr[p];
            pi  = mi[p];
            mr[p] = clamp12((pr + tr) >>> 1);
            mi[p] = clamp12((pi + ti) >>> 1);
            mr[q] = clamp12((pr - tr) >>> 1);
            mi[q] = clamp12((pi - ti) >>> 1);
         end
      end
      for (int n = 0; n < 8; n++) begin
         er = 12'(mr[n]);
         ei = 12'(mi[n]);
         exp_q.push_back({er, ei});
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_frame(input int gap_max);
      int to;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b0;
         if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
         bus.in_valid = 1'b1;
         bus.X_r = 12'(in_r[i]);
         bus.X_i = 12'(in_i[i]);
         to = 0;
         while (!bus.in_ready && to < 60) begin
            @(negedge clk);
            to++;
         end
         if (to >= 60) begin
            checks++;
            errors++;
            $display("FAIL send_timeout sample=%0d in_ready=%0b required=1", i, bus.in_ready);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         acc_cyc = cyc;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic recv_frame(input int stall_idx);
      int wait_n;
      logic [11:0] hr, hi;
      logic hl;
      logic [23:0] e;
      bus.out_ready = 1'b1;
      wait_n = 0;
      while (!bus.out_valid && wait_n < 40) begin
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_compute got=%0b required=0", bus.in_ready);
         end
         @(negedge clk);
         wait_n++;
      end
      checks++;
      if ((cyc - acc_cyc) !== 12) begin
         errors++;
         $display("FAIL latency got=%0d required=12", cyc - acc_cyc);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid beat=%0d got=%0b required=1", i, bus.out_valid);
            break;
         end
         if (i == stall_idx) begin
            bus.out_ready = 1'b0;
            hr = bus.x_r;
            hi = bus.x_i;
            hl = bus.out_last;
            repeat (5) begin
               @(negedge clk);
               checks++;
               if (bus.x_r !== hr || bus.x_i !== hi || bus.out_last !== hl ||
                   bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_hold got=(%0d,%0d,last=%0b,v=%0b,r=%0b) required=(%0d,%0d,last=%0b,v=1,r=0)",
                           $signed(bus.x_r), $signed(bus.x_i), bus.out_last, bus.out_valid,
                           bus.in_ready, $signed(hr), $signed(hi), hl);
               end
            end
            bus.out_ready = 1'b1;
         end
         got_r[i] = int'($signed(bus.x_r));
         got_i[i] = int'($signed(bus.x_i));
         checks++;
         if (bus.out_last !== (i == 7)) begin
            errors++;
            $display("FAIL out_last beat=%0d got=%0b required=%0b", i, bus.out_last, (i == 7));
         end
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_unload beat=%0d got=%0b required=0", i, bus.in_ready);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty beat=%0d got=empty required=entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.x_r, bus.x_i} !== e) begin
               errors++;
               $display("FAIL sample beat=%0d got=(%0d,%0d) required=(%0d,%0d)", i,
                        $signed(bus.x_r), $signed(bus.x_i), $signed(e[23:12]), $signed(e[11:0]));
            end
         end
         @(negedge clk);
      end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_end got=(r=%0b,v=%0b) required=(r=1,v=0)", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic fill_const(input int r, input int i);
      for (int n = 0; n < 8; n++) begin
         in_r[n] = r;
         in_i[n] = i;
      end
   endtask

   task automatic fill_random();
      for (int n = 0; n < 8; n++) begin
         in_r[n] = int'($urandom_range(4095, 0)) - 2048;
         in_i[n] = int'($urandom_range(4095, 0)) - 2048;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
          bus.x_r !== 12'd0 || bus.x_i !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs got=(r=%0b,v=%0b,l=%0b,%0d,%0d) required=(0,0,0,0,0)",
                  bus.in_ready, bus.out_valid, bus.out_last, $signed(bus.x_r), $signed(bus.x_i));
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got=(r=%0b,v=%0b) required=(r=1,v=0)", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_impulse();
      fill_const(0, 0);
      in_r[0] = 1024;
      model_push();
      send_frame(0);
      recv_frame(-1);
      for (int n = 0; n < 8; n++) begin
         checks++;
         if (got_r[n] !== 128 || got_i[n] !== 0) begin
            errors++;
            $display("FAIL impulse n=%0d got=(%0d,%0d) required=(128,0)", n, got_r[n], got_i[n]);
         end
      end
   endtask

   task automatic test_dc();
      fill_const(1024, 0);
      model_push();
      send_frame(0);
      recv_frame(-1);
      for (int n = 0; n < 8; n++) begin
         checks++;
         if (got_r[n] !== (n == 0 ? 1024 : 0) || got_i[n] !== 0) begin
            errors++;
            $display("FAIL dc n=%0d got=(%0d,%0d) required=(%0d,0)", n, got_r[n], got_i[n],
                     (n == 0 ? 1024 : 0));
         end
      end
   endtask

   task automatic test_single_bin();
      int ideal_r [8] = '{1280, 905, 0, -905, -1280, -905, 0, 905};
      int ideal_i [8] = '{0, 905, 1280, 905, 0, -905, -1280, -905};
      int dr, di;
      fill_const(0, 0);
      in_r[1] = 1024;
      model_push();
      send_frame(0);
      recv_frame(-1);
      for (int n = 0; n < 8; n++) begin
         dr = got_r[n] * 10 - ideal_r[n];
         di = got_i[n] * 10 - ideal_i[n];
         checks++;
         if (dr > 20 || dr < -20 || di > 20 || di < -20) begin
            errors++;
            $display("FAIL single_bin n=%0d got=(%0d,%0d) required_x10=(%0d,%0d)+-20",
                     n, got_r[n], got_i[n], ideal_r[n], ideal_i[n]);
         end
      end
   endtask

   task automatic test_saturation();
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) fill_const(2047, 2047);
         else fill_const(-2048, -2048);
         model_push();
         send_frame(0);
         recv_frame(-1);
         for (int n = 0; n < 8; n++) begin
            checks++;
            if (got_r[n] > 2047 || got_r[n] < -2048 || got_i[n] > 2047 || got_i[n] < -2048) begin
               errors++;
               $display("FAIL sat_range pass=%0d n=%0d got=(%0d,%0d) required=[-2048,2047]",
                        pass, n, got_r[n], got_i[n]);
            end
         end
      end
   endtask

   task automatic test_handshake();
      for (int f = 0; f < 3; f++) begin
         fill_random();
         model_push();
         send_frame(3);
         recv_frame(3);
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         fill_random();
         model_push();
         send_frame(0);
         recv_frame(-1);
      end
   endtask

   task automatic test_reset_mid();
      int wait_n;
      logic seen;
      // abort during COMPUTE
      fill_random();
      send_frame(0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_compute got=(v=%0b,r=%0b) required=(v=0,r=0)", bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_compute_release in_ready got=%0b required=1", bus.in_ready);
      end
      seen = 1'b0;
      repeat (16) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_compute_leak out_valid_seen=%0b required=0", seen);
      end
      // abort during UNLOAD at out_idx 4
      fill_random();
      send_frame(0);
      bus.out_ready = 1'b1;
      wait_n = 0;
      while (!bus.out_valid && wait_n < 40) begin
         @(negedge clk);
         wait_n++;
      end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.x_r !== 12'd0 || bus.x_i !== 12'd0) begin
         errors++;
         $display("FAIL rst_unload got=(v=%0b,%0d,%0d) required=(v=0,0,0)",
                  bus.out_valid, $signed(bus.x_r), $signed(bus.x_i));
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_unload_release got=(r=%0b,v=%0b) required=(r=1,v=0)", bus.in_ready, bus.out_valid);
      end
      test_impulse();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.in_valid  = 1'b0;
      bus.X_r       = '0;
      bus.X_i       = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_impulse();
      test_dc();
      test_single_bin();
      test_saturation();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout cycles=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
